// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for a small RISC-V-style datapath: fetch, decode, execute, memory and writeback.
// Strobes come from the current state. The FETCH handshake, the branch decision and reset act within the same cycle.
module multicycle_control_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      r_state;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [31:0] r_instret;

  logic w_branch_ok;
  logic w_taken;

  assign w_branch_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001);
  assign w_taken     = ((r_funct3 == 3'b000) && zero) || ((r_funct3 == 3'b001) && !zero);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          // The port value seen here is the one being latched, so it is safe to branch on it.
          r_opcode <= opcode;
          r_funct3 <= funct3;
          case (opcode)
            OP_R:              r_state <= S_EXEC_R;
            OP_I:              r_state <= S_EXEC_I;
            OP_LOAD, OP_STORE: r_state <= S_ADDR;
            OP_BRANCH:         r_state <= S_BRANCH;
            default:           r_state <= S_TRAP;
          endcase
        end
        S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
        S_ADDR:   r_state <= (r_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (mem_ready) r_state <= S_WB_MEM;
        S_MEM_WR: if (mem_ready) begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + 32'd1;
        end
        S_WB_ALU, S_WB_MEM: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + 32'd1;
        end
        S_BRANCH: if (w_branch_ok) begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + 32'd1;
        end else begin
          r_state <= S_TRAP;
        end
        default:  r_state <= S_TRAP;
      endcase
    end
  end

  // Reset masks every output combinationally so no access can complete while reset_n is low.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_sel    = 2'b00;
    illegal    = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          imm_sel   = (r_opcode == OP_STORE) ? 2'b01 : 2'b00;
        end
        S_MEM_RD: mem_read = 1'b1;
        S_MEM_WR: mem_write = 1'b1;
        S_WB_ALU: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          imm_sel   = 2'b10;
          pc_src    = 1'b1;
          pc_write  = w_taken;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule
